// File: rtl/adc_fifo_drain_arbiter_pkg.sv
// Shared types and helpers for the ADC FIFO drain arbiter.
// Holds the FSM state type, header tag default and round-robin search.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        LAT,
        DATA
    } state_t;

    localparam logic [3:0] HDR_TAG_DEF = 4'hA;

    // Returns {found, index}: first set request above ptr, wrapping mod n.
    function automatic logic [4:0] rr_pick(
        input logic [15:0] req,
        input logic [3:0]  ptr,
        input int          n
    );
        logic [4:0] r;
        int         idx;
        r = '0;
        for (int i = 1; i <= 16; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i <= n && !r[4] && req[idx[3:0]]) begin
                r = {1'b1, idx[3:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_fifo_drain_arbiter_picker.sv
// Combinational round-robin priority search over up to 16 requesters.
// The search starts at ptr+1 so the last served channel goes last.
module rr_priority_picker
    import adc_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [3:0]        ptr,
    output logic [3:0]        idx,
    output logic              found
);

    logic [15:0] req_w;
    logic [4:0]  pick;

    // Widen the request vector to the helper's fixed 16-bit form
    always_comb begin
        req_w             = '0;
        req_w[NUM_CH-1:0] = req;
    end

    assign pick  = rr_pick(req_w, ptr, NUM_CH);
    assign found = pick[4];
    assign idx   = pick[3:0];

endmodule

// File: rtl/adc_fifo_drain_arbiter.sv
// Round-robin drain of per-channel byte FIFOs into one packet stream.
// Each packet is a {tag, channel} header followed by 1..BURST_LEN bytes.
module adc_fifo_drain_arbiter
    import adc_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         BURST_LEN = 16,
    parameter logic [3:0] HDR_TAG   = HDR_TAG_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     fifo_not_empty,
    output logic [NUM_CH-1:0]     fifo_rd_en,
    input  logic [NUM_CH*8-1:0]   fifo_dout,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [3:0]            grant_ch
);

    state_t            state;
    logic [3:0]        rr_ptr;
    logic [7:0]        count;
    logic [3:0]        pick_idx;
    logic              pick_found;
    logic [NUM_CH-1:0] sel;
    logic [7:0]        cur_dout;
    logic              cur_ne;
    logic              last_now;

    rr_priority_picker #(
        .NUM_CH(NUM_CH)
    ) u_pick (
        .req  (fifo_not_empty),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // Decode the granted channel into a strobe and select its FIFO side
    always_comb begin
        sel      = '0;
        cur_dout = '0;
        cur_ne   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_ch == 4'(i)) begin
                sel[i]   = 1'b1;
                cur_dout = fifo_dout[8*i +: 8];
                cur_ne   = fifo_not_empty[i];
            end
        end
    end

    // Post-read flag: FIFO ran dry or the burst limit is reached
    assign last_now = (9'(count) + 9'd1 == 9'(BURST_LEN)) || !cur_ne;
    assign busy     = (state != IDLE);

    // Packet FSM: header, then read/latency/data per byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 4'(NUM_CH - 1);
            count      <= '0;
            grant_ch   <= '0;
            fifo_rd_en <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && pick_found) begin
                        grant_ch <= pick_idx;
                        count    <= '0;
                        m_data   <= {HDR_TAG, pick_idx};
                        m_valid  <= 1'b1;
                        m_last   <= 1'b0;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (m_ready) begin
                        m_valid    <= 1'b0;
                        fifo_rd_en <= sel;
                        state      <= RD;
                    end
                end
                RD: begin
                    fifo_rd_en <= '0;
                    state      <= LAT;
                end
                LAT: begin
                    m_data  <= cur_dout;
                    m_last  <= last_now;
                    m_valid <= 1'b1;
                    state   <= DATA;
                end
                DATA: begin
                    if (m_ready) begin
                        count   <= count + 8'd1;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (m_last) begin
                            rr_ptr <= grant_ch;
                            state  <= IDLE;
                        end else begin
                            fifo_rd_en <= sel;
                            state      <= RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_fifo_drain_arbiter.sv
// Self-checking bench for adc_fifo_drain_arbiter.
// FIFO models feed the DUT; a scoreboard holds the expected byte stream.
module tb_adc_fifo_drain_arbiter;

    localparam int NCH = 4;
    localparam int BL  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [NCH-1:0]   fifo_not_empty;
    logic [NCH-1:0]   fifo_rd_en;
    logic [NCH*8-1:0] fifo_dout;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             busy;
    logic [3:0]       grant_ch;

    adc_fifo_drain_arbiter #(
        .NUM_CH   (NCH),
        .BURST_LEN(BL),
        .HDR_TAG  (4'hA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_not_empty(fifo_not_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_dout     (fifo_dout),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .grant_ch      (grant_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    typedef struct {
        int ch;
        int n;
        int base;
        int step;
    } vec_t;

    exp_t       sb[$];
    logic [7:0] fq[NCH][$];
    logic [7:0] dout_r[NCH];
    int         rd_cnt[NCH];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_x = 0;
    bit         in_pkt = 0;
    bit         stall = 0;
    bit         rand_ready = 0;
    logic [7:0] st_d;
    logic       st_l;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < NCH; i++) begin
            fifo_not_empty[i]    = (fq[i].size() != 0);
            fifo_dout[8*i +: 8]  = dout_r[i];
        end
    endtask

    task automatic tick();
        logic [NCH-1:0] rd;
        exp_t           e;
        rd = fifo_rd_en;
        if (stall) begin
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_data", 32'(m_data), 32'(st_d));
            chk("stall_last", 32'(m_last), 32'(st_l));
        end
        stall = m_valid && !m_ready;
        st_d  = m_data;
        st_l  = m_last;
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer act=%0h exp=none", m_data);
            end else begin
                e = sb.pop_front();
                chk("xfer_data", 32'(m_data), 32'(e.d));
                chk("xfer_last", 32'(m_last), 32'(e.l));
            end
            if (!rand_ready && in_pkt) chk("byte_gap", cyc - last_x, 3);
            in_pkt = !m_last;
            last_x = cyc;
        end
        if (rd != '0) chk("rd_onehot", 32'($countones(rd)), 1);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            if (rd[i]) begin
                rd_cnt[i]++;
                if (fq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_underflow act=ch%0d exp=nonempty", i);
                end else begin
                    dout_r[i] = fq[i].pop_front();
                end
            end
        end
        drive_fifo();
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic load(input int ch, input int n, input int base,
                        input int step);
        for (int k = 0; k < n; k++) fq[ch].push_back(8'(base + k * step));
        drive_fifo();
    endtask

    task automatic expect_drain(input int ch, input int n, input int base,
                                input int step);
        int k;
        int m;
        k = 0;
        while (k < n) begin
            m = (n - k > BL) ? BL : n - k;
            sb.push_back('{d: {4'hA, 4'(ch)}, l: 1'b0});
            for (int j = 0; j < m; j++) begin
                sb.push_back('{d: 8'(base + (k + j) * step),
                               l: 1'(j == m - 1)});
            end
            k += m;
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < NCH; i++) rd_cnt[i] = 0;
    endtask

    task automatic run_done(input int max, input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < max) begin
            tick();
            k++;
        end
        chk({name, "_done"}, 32'(k < max), 1);
        repeat (4) tick();
    endtask

    vec_t tbl[5];

    initial begin
        int k;
        int tot;
        tbl[0] = '{ch: 2, n: 3,  base: 'h11, step: 'h11};
        tbl[1] = '{ch: 0, n: 20, base: 'h40, step: 1};
        tbl[2] = '{ch: 1, n: 1,  base: 'hC5, step: 0};
        tbl[3] = '{ch: 0, n: 17, base: 'h10, step: 3};
        tbl[4] = '{ch: 3, n: 16, base: 'h80, step: 1};

        rst     = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < NCH; i++) dout_r[i] = '0;
        clr_cnt();
        drive_fifo();
        #2;
        repeat (2) tick();
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_ch), 0);
        rst     = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            clr_cnt();
            load(tbl[v].ch, tbl[v].n, tbl[v].base, tbl[v].step);
            expect_drain(tbl[v].ch, tbl[v].n, tbl[v].base, tbl[v].step);
            run_done(600, "vec");
            tot = 0;
            for (int i = 0; i < NCH; i++) tot += rd_cnt[i];
            chk("vec_rd_cnt", rd_cnt[tbl[v].ch], tbl[v].n);
            chk("vec_rd_total", tot, tbl[v].n);
            chk("vec_busy", 32'(busy), 0);
            chk("vec_grant", 32'(grant_ch), tbl[v].ch);
        end

        clr_cnt();
        load(0, 2, 'h50, 1);
        load(1, 2, 'h60, 1);
        load(3, 2, 'h70, 1);
        expect_drain(0, 2, 'h50, 1);
        expect_drain(1, 2, 'h60, 1);
        expect_drain(3, 4, 'h70, 1);
        expect_drain(0, 2, 'h52, 1);
        k = 0;
        while (!(busy && grant_ch == 4'd1) && k < 200) begin
            tick();
            k++;
        end
        chk("rr_reach_ch1", 32'(k < 200), 1);
        load(0, 2, 'h52, 1);
        load(3, 2, 'h72, 1);
        run_done(600, "rr");
        chk("rr_rd_ch0", rd_cnt[0], 4);
        chk("rr_rd_ch3", rd_cnt[3], 4);

        clr_cnt();
        rand_ready = 1;
        load(1, 6, 'h90, 7);
        expect_drain(1, 6, 'h90, 7);
        run_done(800, "bp");
        rand_ready = 0;
        m_ready    = 1'b1;
        tick();
        chk("bp_rd_cnt", rd_cnt[1], 6);

        clr_cnt();
        in_pkt = 0;
        load(0, 5, 'h30, 1);
        load(1, 3, 'hB0, 1);
        expect_drain(0, 5, 'h30, 1);
        k = 0;
        while (sb.size() > 3 && k < 200) begin
            tick();
            k++;
        end
        chk("en_reach_b2", 32'(k < 200), 1);
        enable = 1'b0;
        run_done(200, "en_off");
        repeat (30) tick();
        chk("en_off_busy", 32'(busy), 0);
        chk("en_off_rd_ch1", rd_cnt[1], 0);
        chk("en_off_rd_ch0", rd_cnt[0], 5);
        enable = 1'b1;
        expect_drain(1, 3, 'hB0, 1);
        run_done(200, "en_on");
        chk("en_on_grant", 32'(grant_ch), 1);

        clr_cnt();
        load(0, 3, 'h5A, 1);
        sb.push_back('{d: 8'hA0, l: 1'b0});
        k = 0;
        while (!fifo_rd_en[0] && k < 100) begin
            tick();
            k++;
        end
        chk("rst_reach_rd", 32'(k < 100), 1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rd_en", 32'(fifo_rd_en), 0);
        chk("arst_valid", 32'(m_valid), 0);
        chk("arst_last", 32'(m_last), 0);
        chk("arst_data", 32'(m_data), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_grant", 32'(grant_ch), 0);
        chk("arst_sb_hdr_done", 32'(sb.size()), 0);
        sb.delete();
        stall  = 0;
        in_pkt = 0;
        repeat (2) tick();
        rst = 1'b0;
        expect_drain(0, 2, 'h5B, 1);
        run_done(200, "post_rst");
        chk("post_rst_rd", rd_cnt[0], 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
